ifu_pfq: RTL and testbench

- Instruction fetch unit with a parametrised prefetch queue, decoupling instruction memory from decode.
- Issues sequential fetch requests over a valid/ready request channel and accepts in-order responses with variable latency.
- Buffers {pc, inst} pairs and presents them to the idu through a valid/ready handshake.
- On redirect from the bru, flushes the queue and discards wrong-path responses still in flight. Replaces the single-cycle pc register.

---
 rtl/npc_pkg.sv | 12 +
 rtl/ifu_fifo.sv | 44 ++++
 rtl/ifu_pfq.sv | 97 +++++++++
 tb/tb_ifu_pfq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared core widths, reset vector and fetch-unit state encoding.
package npc_pkg;
    localparam int CPU_WIDTH = 32;
    localparam int INS_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int INS_BYTES = 4;

    typedef enum logic {
        S_RESET,
        S_RUN
    } ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous {pc, inst} queue; head is read straight from the entry registers.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && !empty;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/ifu_pfq.sv
// ifu_pfq: sequential fetch with a prefetch queue; keep/drop credits discard
// wrong-path responses after a redirect.
module ifu_pfq #(
    parameter int                   CPU_WIDTH = npc_pkg::CPU_WIDTH,
    parameter int                   INS_WIDTH = npc_pkg::INS_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(npc_pkg::RESET_PC),
    parameter int                   DEPTH     = 4,
    parameter int                   MAX_OUT   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_imem_req_valid,
    input  logic                 i_imem_req_ready,
    output logic [CPU_WIDTH-1:0] o_imem_req_addr,
    input  logic                 i_imem_rsp_valid,
    input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
    input  logic                 i_redirect_valid,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_ifu_valid,
    input  logic                 i_idu_ready,
    output logic [INS_WIDTH-1:0] o_ifu_inst,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic [CPU_WIDTH-1:0] o_fetch_pc
);
    import npc_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int EW = CPU_WIDTH + INS_WIDTH;

    ifu_state_e           state;
    logic [CPU_WIDTH-1:0] fetch_pc, fill_pc, stale_addr, tgt;
    logic [OW-1:0]        keep_cnt, drop_cnt;
    logic [CW-1:0]        count;
    logic [EW-1:0]        head;
    logic                 stale, run, can_issue, req_fire, rsp_drop, push, pop, full, empty;

    assign run       = state == S_RUN;
    assign can_issue = (int'(count) + int'(keep_cnt) < DEPTH) && (int'(keep_cnt) + int'(drop_cnt) < MAX_OUT);
    // a request caught by a redirect keeps its old address until the memory takes it
    assign o_imem_req_valid = run && (stale || can_issue);
    assign o_imem_req_addr  = run ? (stale ? stale_addr : fetch_pc) : '0;
    assign req_fire  = o_imem_req_valid && i_imem_req_ready;
    assign rsp_drop  = drop_cnt != '0;
    assign push      = i_imem_rsp_valid && !rsp_drop && !i_redirect_valid;
    assign pop       = i_idu_ready && !i_redirect_valid;
    assign tgt       = i_redirect_pc & ~CPU_WIDTH'(3);
    assign o_ifu_valid = !empty;
    assign o_ifu_pc    = empty ? '0 : head[EW-1:INS_WIDTH];
    assign o_ifu_inst  = empty ? '0 : head[INS_WIDTH-1:0];
    assign o_fetch_pc  = fetch_pc;

    ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect_valid),
        .din   ({fill_pc, i_imem_rsp_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_RESET;
            fetch_pc   <= RESET_PC;
            fill_pc    <= RESET_PC;
            keep_cnt   <= '0;
            drop_cnt   <= '0;
            stale      <= 1'b0;
            stale_addr <= '0;
        end else begin
            state <= S_RUN;
            if (i_redirect_valid) begin
                fetch_pc   <= tgt;
                fill_pc    <= tgt;
                keep_cnt   <= '0;
                drop_cnt   <= keep_cnt + drop_cnt + OW'(req_fire) - OW'(i_imem_rsp_valid);
                stale      <= o_imem_req_valid && !i_imem_req_ready;
                stale_addr <= o_imem_req_addr;
            end else begin
                if (req_fire && !stale) fetch_pc <= fetch_pc + CPU_WIDTH'(INS_BYTES);
                if (push) fill_pc <= fill_pc + CPU_WIDTH'(INS_BYTES);
                keep_cnt <= keep_cnt + OW'(req_fire && !stale) - OW'(i_imem_rsp_valid && !rsp_drop);
                drop_cnt <= drop_cnt + OW'(req_fire && stale) - OW'(i_imem_rsp_valid && rsp_drop);
                if (req_fire) stale <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) assert (!(push && full));
    end
endmodule

// File: tb/tb_ifu_pfq.sv
// tb_ifu_pfq: randomized in-order memory model plus a pc-stream scoreboard for ifu_pfq.
module tb_ifu_pfq;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid, req_ready = 1'b0, rsp_valid = 1'b0, redirect_valid = 1'b0;
    logic ifu_valid, idu_ready = 1'b0;
    logic [31:0] req_addr, rsp_data = '0, redirect_pc = '0, ifu_inst, ifu_pc, fetch_pc;

    always #5 clk = ~clk;

    ifu_pfq #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_ifu_valid(ifu_valid), .i_idu_ready(idu_ready), .o_ifu_inst(ifu_inst), .o_ifu_pc(ifu_pc),
        .o_fetch_pc(fetch_pc)
    );

    int checks = 0, errors = 0, cyc = 0, nfire = 0, npop = 0;
    int rdy_pct = 100, idu_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] mq_addr[$];
    int mq_due[$];
    logic [31:0] exp_pc = RST_PC, prev_addr, last_fire_addr, last_pop_pc;
    bit prev_pend = 0, last_fire = 0, last_pop = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    // one clock of memory model + scoreboard; architectural stream restarts at each redirect target
    task automatic step(input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data = inst_of(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data = $urandom;
        end
        req_ready = $urandom_range(99) < rdy_pct;
        idu_ready = $urandom_range(99) < idu_pct;
        redirect_valid = redir;
        redirect_pc = rpc;
        #1;
        if (prev_pend) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: valid=%0b addr=%h, required valid=1 addr=%h", req_valid, req_addr, prev_addr);
            end
        end
        if (req_valid) begin
            checks++;
            if (req_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL req_align: addr=%h, required low bits 00", req_addr);
            end
        end
        last_fire = req_valid && req_ready;
        if (last_fire) begin
            mq_addr.push_back(req_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            last_fire_addr = req_addr;
            nfire++;
            checks++;
            if (mq_addr.size() > MAX_OUT) begin
                errors++;
                $display("FAIL outstanding: %0d in flight, required <= %0d", mq_addr.size(), MAX_OUT);
            end
        end
        prev_pend = req_valid && !req_ready;
        prev_addr = req_addr;
        last_pop = ifu_valid && idu_ready && !redir;
        if (last_pop) begin
            last_pop_pc = ifu_pc;
            npop++;
            checks++;
            if (ifu_pc !== exp_pc || ifu_inst !== inst_of(exp_pc)) begin
                errors++;
                $display("FAIL pop_stream: pc=%h inst=%h, required pc=%h inst=%h", ifu_pc, ifu_inst, exp_pc, inst_of(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = rpc & ~32'h3;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; rsp_valid = 1'b0; redirect_valid = 1'b0; req_ready = 1'b0; idu_ready = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        prev_pend = 0;
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        exp_pc = RST_PC;
        #1;
    endtask

    task automatic knobs(input int r, input int d, input int lmin, input int lmax);
        rdy_pct = r; idu_pct = d; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] want);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(0, 0);
            got = last_pop;
        end
        checks++;
        if (!got || last_pop_pc !== want) begin
            errors++;
            $display("FAIL %s: popped=%0b pc=%h, required pc=%h", name, got, last_pop_pc, want);
        end
    endtask

    task automatic test_reset();
        knobs(100, 100, 1, 1);
        do_reset(3);
        checks += 6;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: %0b, required 0", req_valid); end
        if (req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: %h, required 0", req_addr); end
        if (ifu_valid !== 1'b0) begin errors++; $display("FAIL rst_ifu_valid: %0b, required 0", ifu_valid); end
        if (ifu_pc !== 32'h0) begin errors++; $display("FAIL rst_ifu_pc: %h, required 0", ifu_pc); end
        if (ifu_inst !== 32'h0) begin errors++; $display("FAIL rst_ifu_inst: %h, required 0", ifu_inst); end
        if (fetch_pc !== RST_PC) begin errors++; $display("FAIL rst_fetch_pc: %h, required %h", fetch_pc, RST_PC); end
        release_rst();
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_no_req_in_reset: %0b, required 0", req_valid); end
        step(0, 0);
        checks++;
        if (!last_fire || last_fire_addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_first_req: fire=%0b addr=%h, required fire=1 addr=%h", last_fire, last_fire_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        int ff = -1, fv = -1, k = 0, p0;
        logic [31:0] fpc = '0;
        knobs(100, 100, 1, 1);
        do_reset(2);
        release_rst();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) p0 = npop;
            if (ifu_valid && fv < 0 && i > 0) begin fv = i; fpc = ifu_pc; end
            step(0, 0);
            if (ifu_valid && fv < 0) begin fv = i; fpc = ifu_pc; end
            if (last_fire) begin
                if (ff < 0) ff = i;
                checks++;
                if (last_fire_addr !== RST_PC + 32'(4 * k)) begin
                    errors++;
                    $display("FAIL seq_addr: %h, required %h", last_fire_addr, RST_PC + 32'(4 * k));
                end
                k++;
            end
        end
        checks += 3;
        if (fv - ff != 2) begin errors++; $display("FAIL seq_latency: %0d cycles, required 2", fv - ff); end
        if (fpc !== RST_PC) begin errors++; $display("FAIL seq_first_pc: %h, required %h", fpc, RST_PC); end
        if (npop - p0 != 15) begin errors++; $display("FAIL seq_throughput: %0d pops in 15 cycles, required 15", npop - p0); end
    endtask

    task automatic test_backpressure();
        int f0, p0;
        knobs(100, 0, 1, 1);
        do_reset(2);
        release_rst();
        f0 = nfire;
        for (int i = 0; i < 20; i++) step(0, 0);
        checks += 3;
        if (nfire - f0 != 4) begin errors++; $display("FAIL bp_req_count: %0d, required 4", nfire - f0); end
        if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stop: valid=%0b, required 0", req_valid); end
        if (ifu_valid !== 1'b1) begin errors++; $display("FAIL bp_head_valid: %0b, required 1", ifu_valid); end
        idu_pct = 100;
        f0 = nfire;
        p0 = npop;
        for (int i = 0; i < 20; i++) step(0, 0);
        checks += 2;
        if (npop - p0 < 16) begin errors++; $display("FAIL bp_resume_pops: %0d, required >= 16", npop - p0); end
        if (nfire - f0 < 12) begin errors++; $display("FAIL bp_resume_reqs: %0d, required >= 12", nfire - f0); end
    endtask

    task automatic test_redirect_inflight();
        int f0;
        bit got = 0;
        knobs(100, 100, 5, 5);
        do_reset(2);
        release_rst();
        f0 = nfire;
        for (int i = 0; i < 10 && nfire - f0 < 3; i++) step(0, 0);
        step(1, 32'h8000_0102);
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 0);
            got = last_fire;
        end
        checks++;
        if (!got || last_fire_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rdi_next_addr: fire=%0b addr=%h, required 80000100", got, last_fire_addr);
        end
        wait_pop("rdi_first_pc", 32'h8000_0100);
    endtask

    task automatic test_redirect_pending();
        knobs(100, 100, 1, 1);
        do_reset(2);
        release_rst();
        for (int i = 0; i < 3; i++) step(0, 0);
        step(1, 32'h8000_0010);
        rdy_pct = 0;
        step(0, 0);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rdp_pending: valid=%0b addr=%h, required 1 80000010", req_valid, req_addr);
        end
        step(1, 32'h8000_0406);
        for (int i = 0; i < 3; i++) step(0, 0);
        checks++;
        if (req_addr !== 32'h8000_0010) begin errors++; $display("FAIL rdp_hold_addr: %h, required 80000010", req_addr); end
        rdy_pct = 100;
        step(0, 0);
        checks++;
        if (!last_fire || last_fire_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rdp_old_accept: fire=%0b addr=%h, required 80000010", last_fire, last_fire_addr);
        end
        step(0, 0);
        checks++;
        if (!last_fire || last_fire_addr !== 32'h8000_0404) begin
            errors++;
            $display("FAIL rdp_target_req: fire=%0b addr=%h, required 80000404", last_fire, last_fire_addr);
        end
        wait_pop("rdp_first_pc", 32'h8000_0404);
    endtask

    task automatic test_redirect_collision();
        int p0;
        knobs(100, 100, 1, 1);
        do_reset(2);
        release_rst();
        for (int i = 0; i < 8; i++) step(0, 0);
        step(1, 32'h8000_0300);
        checks++;
        if (ifu_valid !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL col_setup: head valid=%0b rsp=%0b, required both 1", ifu_valid, rsp_valid);
        end
        step(0, 0);
        checks += 2;
        if (ifu_valid !== 1'b0) begin errors++; $display("FAIL col_flushed: valid=%0b, required 0", ifu_valid); end
        if (!last_fire || last_fire_addr !== 32'h8000_0300) begin
            errors++;
            $display("FAIL col_next_req: fire=%0b addr=%h, required 80000300", last_fire, last_fire_addr);
        end
        p0 = npop;
        wait_pop("col_first_pc", 32'h8000_0300);
        for (int i = 0; i < 10; i++) step(0, 0);
        checks++;
        if (npop - p0 < 8) begin errors++; $display("FAIL col_flow: %0d pops, required >= 8", npop - p0); end
    endtask

    task automatic test_wrap();
        knobs(100, 100, 1, 1);
        do_reset(2);
        release_rst();
        step(1, 32'hFFFF_FFFC);
        step(0, 0);
        checks++;
        if (!last_fire || last_fire_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req0: fire=%0b addr=%h, required FFFFFFFC", last_fire, last_fire_addr);
        end
        step(0, 0);
        checks++;
        if (!last_fire || last_fire_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req1: fire=%0b addr=%h, required 00000000", last_fire, last_fire_addr);
        end
        wait_pop("wrap_pop0", 32'hFFFF_FFFC);
        wait_pop("wrap_pop1", 32'h0000_0000);
    endtask

    task automatic test_mid_reset();
        bit got = 0;
        knobs(70, 70, 1, 3);
        for (int i = 0; i < 30; i++) step(0, 0);
        do_reset(1);
        checks += 4;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL mrst_req_valid: %0b, required 0", req_valid); end
        if (ifu_valid !== 1'b0) begin errors++; $display("FAIL mrst_ifu_valid: %0b, required 0", ifu_valid); end
        if (ifu_pc !== 32'h0) begin errors++; $display("FAIL mrst_ifu_pc: %h, required 0", ifu_pc); end
        if (fetch_pc !== RST_PC) begin errors++; $display("FAIL mrst_fetch_pc: %h, required %h", fetch_pc, RST_PC); end
        release_rst();
        rdy_pct = 100;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 0);
            got = last_fire;
        end
        checks++;
        if (!got || last_fire_addr !== RST_PC) begin
            errors++;
            $display("FAIL mrst_restart: fire=%0b addr=%h, required %h", got, last_fire_addr, RST_PC);
        end
        wait_pop("mrst_first_pc", RST_PC);
    endtask

    task automatic test_random();
        int p0;
        do_reset(2);
        release_rst();
        p0 = npop;
        for (int s = 0; s < 30; s++) begin
            knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1, int'($urandom_range(6, 1)));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(19) == 0) step(1, $urandom);
                else step(0, 0);
            end
        end
        checks++;
        if (npop - p0 < 100) begin errors++; $display("FAIL rand_progress: %0d pops, required >= 100", npop - p0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pending();
        test_redirect_collision();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
